// File: rtl/scarv_cop_dispatch_if.sv
// Signal bundle between the ISE dispatcher, the host CPU, the ISE decoder and
// the per-class functional units. The dispatcher uses the slave modport.
interface scarv_cop_dispatch_if #(
  parameter int CNT_W = 32
);
  logic             cpu_insn_req;
  logic             cpu_insn_ack;
  logic [31:0]      cpu_insn_enc;
  logic             cpu_rsp_valid;
  logic             cpu_rsp_ack;
  logic [2:0]       cpu_rsp_status;
  logic             cop_flush;
  logic [31:0]      dec_encoded;
  logic             id_exception;
  logic [3:0]       id_class;
  logic [15:0]      fu_ivalid;
  logic [15:0]      fu_iready;
  logic [15:0]      fu_idone;
  logic             fu_ierror;
  logic             busy;
  logic [CNT_W-1:0] insn_retired;

  modport slave (
    input  cpu_insn_req, cpu_insn_enc, cpu_rsp_ack, cop_flush,
    input  id_exception, id_class,
    input  fu_iready, fu_idone, fu_ierror,
    output cpu_insn_ack, cpu_rsp_valid, cpu_rsp_status,
    output dec_encoded, fu_ivalid, busy, insn_retired
  );

  modport master (
    output cpu_insn_req, cpu_insn_enc, cpu_rsp_ack, cop_flush,
    output id_exception, id_class,
    output fu_iready, fu_idone, fu_ierror,
    input  cpu_insn_ack, cpu_rsp_valid, cpu_rsp_status,
    input  dec_encoded, fu_ivalid, busy, insn_retired
  );
endinterface

// File: rtl/scarv_cop_dispatch.sv
// ISE coprocessor instruction sequencer: accept -> decode -> issue -> wait -> respond.
// Optional WAIT watchdog enabled by defining SCARV_COP_DISPATCH_TIMEOUT_EN.
module scarv_cop_dispatch #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  scarv_cop_dispatch_if.slave  cop
);

  localparam logic [2:0] STATUS_OK       = 3'd0;
  localparam logic [2:0] STATUS_ILLEGAL  = 3'd1;
  localparam logic [2:0] STATUS_FU_ERROR = 3'd2;
`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
  localparam logic [2:0] STATUS_TIMEOUT  = 3'd3;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [31:0]      dec_encoded_q;
  logic [3:0]       class_q;
  logic [2:0]       status_q;
  logic [2:0]       status_d;
  logic [CNT_W-1:0] retired_q;

  logic             latch_insn;
  logic             latch_class;
  logic             status_we;
  logic             retire;

  function automatic logic [15:0] class_onehot(input logic [3:0] cls);
    return 16'd1 << cls;
  endfunction

  function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
    return v + CNT_W'(1);
  endfunction

`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] wait_cnt_q;
  logic             timeout_hit;

  // Held at zero outside WAIT so every WAIT visit starts counting from 0;
  // the TIMEOUT_CYCLES-th WAIT cycle is the one that gives up.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      wait_cnt_q <= '0;
    end else if (state_q != WAIT) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + TMR_W'(1);
    end
  end

  assign timeout_hit = (wait_cnt_q == TMR_W'(TIMEOUT_CYCLES - 1));
`endif

  // ---- next-state / control decode ----
  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    latch_insn  = 1'b0;
    latch_class = 1'b0;
    status_we   = 1'b0;
    retire      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cop.cpu_insn_req) begin
          latch_insn = 1'b1;
          state_d    = DECODE;
        end
      end

      DECODE: begin
        if (cop.cop_flush) begin
          state_d = IDLE;
        end else if (cop.id_exception || (cop.id_class == 4'd0)) begin
          status_we = 1'b1;
          status_d  = STATUS_ILLEGAL;
          state_d   = RESP;
        end else begin
          latch_class = 1'b1;
          state_d     = ISSUE;
        end
      end

      // A handshake in the same cycle as a flush commits the instruction.
      ISSUE: begin
        if (cop.fu_iready[class_q]) begin
          state_d = WAIT;
        end else if (cop.cop_flush) begin
          state_d = IDLE;
        end
      end

      WAIT: begin
        if (cop.fu_idone[class_q]) begin
          status_we = 1'b1;
          status_d  = cop.fu_ierror ? STATUS_FU_ERROR : STATUS_OK;
          state_d   = RESP;
        end
`ifdef SCARV_COP_DISPATCH_TIMEOUT_EN
        else if (timeout_hit) begin
          status_we = 1'b1;
          status_d  = STATUS_TIMEOUT;
          state_d   = RESP;
        end
`endif
      end

      RESP: begin
        if (cop.cpu_rsp_ack) begin
          retire  = (status_q == STATUS_OK);
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---- state and control registers ----
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q       <= IDLE;
      dec_encoded_q <= '0;
      status_q      <= STATUS_OK;
      retired_q     <= '0;
    end else begin
      state_q <= state_d;
      if (latch_insn) begin
        dec_encoded_q <= cop.cpu_insn_enc;
      end
      if (status_we) begin
        status_q <= status_d;
      end
      if (retire) begin
        retired_q <= wrap_inc(retired_q);
      end
    end
  end

  // Only consulted in ISSUE/WAIT, which are always preceded by a DECODE load.
  always_ff @(posedge g_clk) begin
    if (latch_class) begin
      class_q <= cop.id_class;
    end
  end

  // ---- outputs: registers or pure state decode ----
  assign cop.cpu_insn_ack   = (state_q == IDLE);
  assign cop.cpu_rsp_valid  = (state_q == RESP);
  assign cop.cpu_rsp_status = status_q;
  assign cop.dec_encoded    = dec_encoded_q;
  assign cop.fu_ivalid      = (state_q == ISSUE) ? class_onehot(class_q) : 16'd0;
  assign cop.busy           = (state_q != IDLE);
  assign cop.insn_retired   = retired_q;

endmodule
